md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated inside the EX stage of the five-stage pipeline. EX launches an operation with a one-cycle `Start` pulse. The unit raises `Busy` for the operation's latency and then commits the result to HI/LO. The ID stage uses `Start || Busy` to stall any following HI/LO-touching instruction.

## Interface
- `MULT_CYCLES`, 5: Busy duration for mult/multu/madd.
- `DIV_CYCLES`, 10: Busy duration for div/divu.

- `clk` input 1: the single clock; everything updates on the rising edge.
- `reset` input 1: synchronous and active-high.
- `Start` input 1: one-cycle launch strobe, sampled with `MDOp`.
- `MDOp` input 3: operation select. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd.
- `A` input 32: rs operand, after forwarding.
- `B` input 32: rt operand, after forwarding.
- `Busy` output 1: high while an operation is in flight.
- `HI` output 32: architectural HI register (registered).
- `LO` output 32: architectural LO register (registered).

## Operation
- State is IDLE or RUN.
  - IDLE: `Busy`=0, counter=0.
  - RUN: `Busy`=1 and counter>0.
- Start sampled in IDLE with MDOp 1–4 (or 7 when enabled):
  - Compute the result from A and B, latch it into internal `pend_hi`/`pend_lo`.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES) and enter RUN.
- In RUN, the counter decrements each edge. On the edge where it goes 1→0:
  - HI←pend_hi, LO←pend_lo.
  - Return to IDLE.
- mthi/mtlo (MDOp 5/6 with Start): HI←A or LO←A at that same edge. Busy never rises.
- MDOp 0 with Start: no effect.
- Start sampled while Busy=1: ignored entirely, in-flight operation continues. The hazard unit guarantees this does not occur; the bench checks it anyway.
- Arithmetic rules:
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: the same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: the same, unsigned.
  - Divide by zero (B=0): full DIV_CYCLES Busy, then HI/LO unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Implementation may be a single-cycle behavioural compute plus delay counter, or iterative. Only the cycle-level visible behaviour below is normative.

## Timing
- Reset values: Busy=0, HI=0, LO=0, counter=0, pending results cleared.
- Start sampled at edge k: Busy=1 from just after edge k through edge k+N. It is 0 after edge k+N, in the same cycle the new HI/LO become visible.
- Busy is therefore high for exactly N cycles. Busy is never high in the Start cycle itself; the external stall covers that cycle via Start.
- HI/LO hold their old values throughout RUN. mfhi/mflo issued during RUN are stalled upstream, never served stale-by-design.
- Reset during RUN: abort at that edge. Busy=0, HI/LO=0, pending result discarded.
- Reset has priority over Start in the same cycle.
- mthi/mtlo latency 1: new value is visible the cycle after Start.

## Configuration
- `MD_UNIT_MADD_EN` defined:
  - MDOp 7 = madd, {HI,LO} ← {HI,LO} + signed(A)×signed(B), wrapping modulo 2^64.
  - Busy for MULT_CYCLES.
  - The accumulate uses the HI/LO values at commit time.
- `MD_UNIT_MADD_EN` undefined: MDOp 7 behaves as MDOp 0 (no Busy, no HI/LO change). No madd adder is synthesised.

## Test plan
- mult with A=0xFFFFFFFF, B=2, Start at edge 0:
  - Busy=1 for cycles 1–5.
  - After edge 5: Busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- div with A=0xFFFFFFF9 (−7), B=2: Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with A=0xFFFFFFF9, B=2: LO=0x7FFFFFFC, HI=1.
- divu with B=0 after mthi A=0x1234 and mtlo A=0x5678:
  - 10 Busy cycles, then HI=0x1234, LO=0x5678.
  - A second Start with MDOp=1 mid-run is ignored.
- Reset and madd:
  - Assert reset at Busy cycle 3 of a mult: next cycle Busy=0, HI=LO=0, and no late commit.
  - With `MD_UNIT_MADD_EN`: HI=0, LO=0xFFFFFFFF, then madd 1×1 gives HI=1, LO=0.

Source files
------------

// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide unit.
// master: EX stage (drives Start/MDOp/A/B, observes Busy/HI/LO).
// slave:  md_unit (consumes the launch, presents Busy and the HI/LO registers).
interface md_unit_if;
    logic        Start;   // one-cycle launch strobe
    logic [2:0]  MDOp;    // 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd
    logic [31:0] A;       // rs operand (forwarded)
    logic [31:0] B;       // rt operand (forwarded)
    logic        Busy;    // operation in flight
    logic [31:0] HI;      // architectural HI
    logic [31:0] LO;      // architectural LO

    modport master (
        output Start, MDOp, A, B,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDOp, A, B,
        output Busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers, launched by a one-cycle Start.
// Latency: mul/multu/madd MULT_CYCLES, div/divu DIV_CYCLES of Busy; mthi/mtlo visible next cycle.
// Backpressure: none internally; Start while Busy is dropped, ID stalls on Start||Busy.
//
// Ports: clk, reset (synchronous, active-high), md (md_unit_if.slave: Start/MDOp/A/B in,
// Busy/HI/LO out). Optional build macro MD_UNIT_MADD_EN enables MDOp 7 (madd); without it
// MDOp 7 is a no-op and no accumulate adder exists.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    hi_q, lo_q;
    logic [31:0]    pend_hi_q, pend_lo_q;
    logic           pend_wr_q;      // cleared for divide-by-zero: commit leaves HI/LO alone
`ifdef MD_UNIT_MADD_EN
    logic           pend_acc_q;     // commit adds the product onto HI/LO instead of overwriting
`endif

    logic is_mul, is_div, is_madd, launch, commit;

    assign is_mul  = (md.MDOp == 3'd1) || (md.MDOp == 3'd2);
    assign is_div  = (md.MDOp == 3'd3) || (md.MDOp == 3'd4);
`ifdef MD_UNIT_MADD_EN
    assign is_madd = (md.MDOp == 3'd7);
`else
    assign is_madd = 1'b0;
`endif
    assign launch  = md.Start && (state_q == IDLE) && (is_mul || is_div || is_madd);

    // Single-cycle behavioural compute; the counter only models the visible latency.
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, quo_mag, rem_mag, quo, rem;

    always_comb begin
        prod_s  = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
        prod_u  = {32'd0, md.A} * {32'd0, md.B};
        // Signed divide via magnitudes: 0x80000000 has magnitude 0x80000000 unsigned,
        // so the overflow case falls out as LO=0x80000000, HI=0 without special handling.
        a_neg   = (md.MDOp == 3'd3) && md.A[31];
        b_neg   = (md.MDOp == 3'd3) && md.B[31];
        a_mag   = a_neg ? (32'd0 - md.A) : md.A;
        b_mag   = b_neg ? (32'd0 - md.B) : md.B;
        b_div   = (b_mag == 32'd0) ? 32'd1 : b_mag;  // keeps the divider defined; result unused
        quo_mag = a_mag / b_div;
        rem_mag = a_mag % b_div;
        quo     = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem     = a_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = RUN;
            RUN:  if (cnt_q == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        md.Busy = (state_q == RUN);
        commit  = (state_q == RUN) && (cnt_q == CW'(1));
    end

    // Counter and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_wr_q  <= 1'b0;
`ifdef MD_UNIT_MADD_EN
            pend_acc_q <= 1'b0;
`endif
        end else begin
            if (launch) begin
                cnt_q     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                pend_wr_q <= !(is_div && (md.B == 32'd0));
                if (is_div)                  {pend_hi_q, pend_lo_q} <= {rem, quo};
                else if (md.MDOp == 3'd2)    {pend_hi_q, pend_lo_q} <= prod_u;
                else                         {pend_hi_q, pend_lo_q} <= prod_s;
`ifdef MD_UNIT_MADD_EN
                pend_acc_q <= is_madd;
`endif
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (commit) begin
                if (pend_wr_q) begin
`ifdef MD_UNIT_MADD_EN
                    if (pend_acc_q) {hi_q, lo_q} <= {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
                    else            {hi_q, lo_q} <= {pend_hi_q, pend_lo_q};
`else
                    {hi_q, lo_q} <= {pend_hi_q, pend_lo_q};
`endif
                end
            end else if (md.Start && (state_q == IDLE)) begin
                if (md.MDOp == 3'd5) hi_q <= md.A;
                if (md.MDOp == 3'd6) lo_q <= md.A;
            end
        end
    end

    assign md.HI = hi_q;
    assign md.LO = lo_q;
endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    typedef struct {
        int          n;
        logic [31:0] hi, lo, old_hi, old_lo;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          mon_cnt = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural effect of one launch, from the arithmetic rules.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output exp_t e);
        longint          sa, sb, sq, sr, sp;
        longint unsigned ua, ub, uq, ur, up;
        logic [63:0]     acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.old_hi = model_hi;
        e.old_lo = model_lo;
        e.n = 0;
        case (op)
            3'd1: begin sp = sa * sb; acc = sp; {model_hi, model_lo} = acc; e.n = MC; end
            3'd2: begin up = ua * ub; {model_hi, model_lo} = up; e.n = MC; end
            3'd3: begin
                e.n = DC;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    model_lo = sq[31:0]; model_hi = sr[31:0];
                end
            end
            3'd4: begin
                e.n = DC;
                if (b != 0) begin
                    uq = ua / ub; ur = ua % ub;
                    model_lo = uq[31:0]; model_hi = ur[31:0];
                end
            end
            3'd5: model_hi = a;
            3'd6: model_lo = a;
`ifdef MD_UNIT_MADD_EN
            3'd7: begin
                sp = sa * sb;
                acc = {model_hi, model_lo} + 64'(sp);
                {model_hi, model_lo} = acc;
                e.n = MC;
            end
`endif
            default: ;
        endcase
        e.hi = model_hi;
        e.lo = model_lo;
    endtask

    // Drive one Start pulse (called at posedge+1), push the expectation after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        exp_t e;
        model_op(op, a, b, e);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.MDOp = 3'd0;
        q.push_back(e);
        n = e.n;
    endtask

    // Stray Start with no expectation: the unit must be busy and ignore it.
    task automatic stray_start(input logic [2:0] op);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = $urandom; bus.B = $urandom;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.MDOp = 3'd0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 64 && q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
            mon_cnt = 0;
        end
    endtask

    task automatic wait_cycles(input int c);
        for (int i = 0; i < c; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(op, a, b, n);
        drain();
    endtask

    // Monitor: samples at negedge, counts Busy cycles, checks result when Busy drops.
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() == 0) begin
                chk("idle_busy", 64'(bus.Busy), 64'd0);
            end else if (bus.Busy) begin
                mon_cnt++;
                if (mon_cnt == 1) begin
                    chk("hold_hi", 64'(bus.HI), 64'(q[0].old_hi));
                    chk("hold_lo", 64'(bus.LO), 64'(q[0].old_lo));
                end
                if (mon_cnt > q[0].n) begin
                    chk("busy_overrun", 64'(mon_cnt), 64'(q[0].n));
                    void'(q.pop_front());
                    mon_cnt = 0;
                end
            end else begin
                chk("busy_cycles", 64'(mon_cnt), 64'(q[0].n));
                chk("hi", 64'(bus.HI), 64'(q[0].hi));
                chk("lo", 64'(bus.LO), 64'(q[0].lo));
                void'(q.pop_front());
                mon_cnt = 0;
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.Start = 1'b0; bus.MDOp = 3'd0; bus.A = '0; bus.B = '0;
        wait_cycles(3);
        reset = 1'b0;

        // Reset state via a no-op launch
        run_op(3'd0, 32'h1111_1111, 32'h2222_2222);

        // Directed vectors
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h0000_1234, 32'd0);
        run_op(3'd6, 32'h0000_5678, 32'd0);
        // divu by zero with a mid-run mult attempt
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, n);
        wait_cycles(3);
        stray_start(3'd1);
        drain();
        run_op(3'd3, 32'h7, 32'd0);

        // Reset during Busy cycle 3 of a mult
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, n);
        wait_cycles(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); mon_cnt = 0;
        model_hi = '0; model_lo = '0;
        issue(3'd0, 32'd0, 32'd0, n);
        issue(3'd0, 32'd0, 32'd0, n);
        drain();
        wait_cycles(4);
        run_op(3'd0, 32'd0, 32'd0);

        // Reset wins over a simultaneous Start
        run_op(3'd5, 32'hCAFE_F00D, 32'd0);
        reset = 1'b1; bus.Start = 1'b1; bus.MDOp = 3'd1; bus.A = 32'd3; bus.B = 32'd3;
        @(posedge clk); #1;
        reset = 1'b0; bus.Start = 1'b0; bus.MDOp = 3'd0;
        model_hi = '0; model_lo = '0;
        run_op(3'd0, 32'd0, 32'd0);

        // madd (or no-op when disabled)
        run_op(3'd6, 32'hFFFF_FFFF, 32'd0);
        run_op(3'd7, 32'd1, 32'd1);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            issue(op, a, b, n);
            if (n > 2 && $urandom_range(0, 2) == 0) begin
                wait_cycles(1);
                stray_start(3'($urandom_range(1, 7)));
            end
            drain();
        end

        wait_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
